// File: rtl/nibble_fifo.sv
// First-word-fall-through FIFO feeding a downstream data register stage.
// Full/empty come from the occupancy counter alone, so the pointers simply wrap.
module nibble_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a word moves only on a rising edge where valid && ready are both 1;
  // ready/valid here depend only on registered state and reset, never on the peer's signal.

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign in_ready  = !w_full  && reset;
  assign out_valid = !w_empty && reset;
  assign w_push    = in_valid  && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Zeroed when empty so the downstream register never captures stale storage.
  assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/nibble_fifo.md
# nibble_fifo

- Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the 4-bit data register stage: it buffers nibbles from a bursty producer and presents them one at a time on `out_data`, which drives that register's `d` input.
- The downstream stage consumes by asserting `out_ready`.
- Single clock domain; all state is reset synchronously by an active-low reset.

## Interface
Parameters:
- `WIDTH`, 4, data word width in bits (≥1).
- `DEPTH`, 4, number of storage entries; power of two, ≥2.

Ports:
- `clk`  input  1  rising-edge clock; all state updates on posedge `clk`.
- `reset`  input  1  synchronous, active-low reset; `reset`=0 sampled at a rising edge of `clk` clears the block.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  FIFO can accept a word this cycle.
- `in_data`  input  WIDTH  word to enqueue.
- `out_valid`  output  1  head word present on `out_data`.
- `out_ready`  input  1  consumer takes the head word this cycle.
- `out_data`  output  WIDTH  head-of-queue word.
- `count`  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- `overflow`  output  1  sticky: a write was attempted while full.

## Operation
- **Push**: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer, then increments the write pointer modulo DEPTH.
- **Pop**: `out_valid && out_ready` at a rising edge increments the read pointer modulo DEPTH.
- **Count update**:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- **Ready and valid**:
  - `in_ready` = (`count` != DEPTH) && (`reset`==1).
  - `out_valid` = (`count` != 0) && (`reset`==1).
  - Both are combinational from registered state plus `reset`; neither depends on `in_valid` or `out_ready`.
- **Read data**: `out_data` = storage[rd_ptr] when `out_valid`=1. It is forced to 0 when `out_valid`=0, so it is deterministic for the downstream register.
- **Full**:
  - `in_ready`=0, and no write occurs even if a pop happens that same cycle. There is no full pass-through.
  - `in_valid`=1 while full sets `overflow`=1 at that edge.
  - `overflow` stays set until reset.
- **Empty**:
  - `out_valid`=0 and no pop occurs regardless of `out_ready`.
  - There is no empty bypass: a word pushed into an empty FIFO appears on `out_data` the cycle after the push.
- **Pointer wrap**: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are decided by `count` only.
- **Handshake rule**: the producer must hold `in_data` stable while `in_valid`=1 and `in_ready`=0. The FIFO holds `out_data` stable while `out_valid`=1 and `out_ready`=0.
- **Reset**:
  - `reset`=0 at an edge sets `count`=0, both pointers=0 and `overflow`=0.
  - The storage array is not cleared.
  - A reset asserted mid-burst discards all contents, and no push or pop is performed on that edge.

## Timing
- Reset values: `count`=0, `overflow`=0, `out_valid`=0, `out_data`=0, `in_ready`=0 while `reset`=0, then `in_ready`=1 from the first cycle after release.
- Write-to-read latency: 1 cycle. A push at edge N gives `out_valid`=1 with that data after edge N.
- Throughput: one push and one pop per cycle sustained whenever 0 < `count` < DEPTH.
- `count`, `overflow` and the pointers are registered. `in_ready`, `out_valid` and `out_data` are combinational from registers and `reset` only, so there is no combinational path from any input data or handshake to any output.

## Test plan
1. **Reset and idle**: hold `reset`=0 for 2 edges, then release with no traffic. Required: `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1, `overflow`=0.
2. **Fill then drain**: push 4'hA, 4'h3, 4'hF, 4'h1 on consecutive cycles with `out_ready`=0.
   - After the fills: `count`=4, `in_ready`=0.
   - Then assert `out_ready`=1: `out_data` reads A, 3, F, 1 on successive cycles, `count` steps 3, 2, 1, 0, and `out_valid` falls after the 4th pop.
3. **Full with simultaneous push and pop**: with DEPTH words stored, assert `in_valid`=1 (data 4'h7) and `out_ready`=1 for one cycle.
   - Required: one pop, no push, `count`=3, `overflow`=1.
   - 4'h7 is not stored.
4. **Streaming and wrap**: hold `in_valid`=`out_ready`=1 and push 4'h0..4'hB, one per cycle, for 12 cycles. Required:
   - `count` stays 1 after the first edge.
   - Outputs appear in order 0..B, each exactly one cycle after it was pushed.
   - Pointers wrap 3 times with no loss.
5. **Pop when empty**: `out_ready`=1 with `count`=0 for 3 cycles. Required: `count` stays 0 and no pointer movement; a later push of 4'h5 reads back as 5.
6. **Reset mid-operation**: store 3 words, then drive `reset`=0 for one edge while `in_valid`=`out_ready`=1. Required:
   - Next cycle: `count`=0, `out_valid`=0, `overflow`=0.
   - Subsequent traffic behaves as from power-up.
